// File: rtl/pipe_pkg.sv
// Shared constants and types for the datapath pipeline stages.
package pipe_pkg;
   localparam int XLEN        = 32;
   localparam int REG_W       = 5;
   localparam int MEM_LAT_MAX = 15;
   // Wide enough to count every legal access latency.
   localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;
endpackage

// File: rtl/data_ram.sv
// Word-addressed synchronous single-port data RAM with a preload parameter.
// Reads return the word as it was before a same-edge write; the read register holds between reads.
module data_ram
   import pipe_pkg::*;
#(
   parameter int    ADDR_W    = 8,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   din,
   output logic [XLEN-1:0]   dout
);
   logic [XLEN-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (re) begin
         dout <= mem[addr];
      end
   end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: MEM_LAT-cycle data memory, branch resolution and MEM/WB register.
// Build macro MEM_MISALIGN_TRAP_EN adds the misalign output and traps unaligned requests.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int    ADDR_W    = 8,
   parameter int    MEM_LAT   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             regwrite,
   input  logic             memtoreg,
   input  logic             er,
   input  logic             ew,
   input  logic             pcsrc,
   input  logic             zero,
   input  logic [XLEN-1:0]  res,
   input  logic [XLEN-1:0]  dw,
   input  logic [REG_W-1:0] AW,
   input  logic [XLEN-1:0]  add2,
   output logic             stall,
   output logic             branch_taken,
   output logic [XLEN-1:0]  branch_target,
   output logic             out_regwrite,
   output logic             out_memtoreg,
   output logic [REG_W-1:0] out_AW,
   output logic [XLEN-1:0]  res_out,
   output logic [XLEN-1:0]  rd_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic             misalign
`endif
);
   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              req;
   logic              trap;
   logic              access;
   logic              done;
   logic              complete;
   logic [ADDR_W-1:0] idx;

   assign req = er | ew;
   assign idx = res[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
   logic unused_res;
   assign unused_res = ^res[XLEN-1:ADDR_W+2];
   assign trap       = req & (res[1:0] != 2'b00);
`else
   logic unused_res;
   assign unused_res = ^{res[XLEN-1:ADDR_W+2], res[1:0]};
   assign trap       = 1'b0;
`endif

   // A trapped request never reaches the memory and so never stalls.
   assign access   = req & ~trap;
   assign done     = (cnt_reg == CNT_W'(MEM_LAT - 1));
   assign stall    = access & ~done;
   assign complete = access & done;

   assign branch_taken  = pcsrc & zero & ~stall;
   assign branch_target = add2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (stall) begin
                  state_reg <= WAIT;
                  cnt_reg   <= CNT_W'(1);
               end
            end
            WAIT: begin
               // Dropping the request mid-access is an upstream flush.
               if (!access || done) begin
                  state_reg <= IDLE;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_regwrite <= 1'b0;
         out_memtoreg <= 1'b0;
         out_AW       <= '0;
         res_out      <= '0;
      end else if (stall) begin
         out_regwrite <= 1'b0;
         out_memtoreg <= 1'b0;
      end else begin
         out_regwrite <= regwrite & ~trap;
         out_memtoreg <= memtoreg;
         out_AW       <= AW;
         res_out      <= res;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign <= 1'b0;
      end else begin
         misalign <= trap;
      end
   end
`endif

   data_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (complete & ew),
      .re    (complete & er),
      .addr  (idx),
      .din   (dw),
      .dout  (rd_out)
   );
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, model-checked random traffic, flush and reset corners.
module tb_mem_stage;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic        regwrite, memtoreg, er, ew, pcsrc, zero;
   logic [31:0] res, dw, add2;
   logic [4:0]  aw;

   logic        stall_a, br_a, rw_a, mtr_a, stall_b, br_b, rw_b, mtr_b;
   logic [4:0]  aw_a, aw_b;
   logic [31:0] bt_a, res_a, rd_a, bt_b, res_b, rd_b;
   logic        mis_a, mis_b;

   mem_stage #(.ADDR_W(8), .MEM_LAT(2), .INIT_FILE("")) u_dut_a (
      .clk(clk), .rst_n(rst_a), .regwrite(regwrite), .memtoreg(memtoreg),
      .er(er), .ew(ew), .pcsrc(pcsrc), .zero(zero), .res(res), .dw(dw),
      .AW(aw), .add2(add2), .stall(stall_a), .branch_taken(br_a),
      .branch_target(bt_a), .out_regwrite(rw_a), .out_memtoreg(mtr_a),
      .out_AW(aw_a), .res_out(res_a), .rd_out(rd_a)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign(mis_a)
`endif
   );

   mem_stage #(.ADDR_W(8), .MEM_LAT(4), .INIT_FILE("")) u_dut_b (
      .clk(clk), .rst_n(rst_b), .regwrite(regwrite), .memtoreg(memtoreg),
      .er(er), .ew(ew), .pcsrc(pcsrc), .zero(zero), .res(res), .dw(dw),
      .AW(aw), .add2(add2), .stall(stall_b), .branch_taken(br_b),
      .branch_target(bt_b), .out_regwrite(rw_b), .out_memtoreg(mtr_b),
      .out_AW(aw_b), .res_out(res_b), .rd_out(rd_b)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign(mis_b)
`endif
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign mis_a = 1'b0;
   assign mis_b = 1'b0;
`endif

   // Outputs of whichever instance is under test.
   bit          sel_b = 1'b0;
   logic        o_stall, o_br, o_rw, o_mtr, o_mis;
   logic [4:0]  o_aw;
   logic [31:0] o_bt, o_res, o_rd;
   always_comb begin
      o_stall = sel_b ? stall_b : stall_a;
      o_br    = sel_b ? br_b    : br_a;
      o_rw    = sel_b ? rw_b    : rw_a;
      o_mtr   = sel_b ? mtr_b   : mtr_a;
      o_mis   = sel_b ? mis_b   : mis_a;
      o_aw    = sel_b ? aw_b    : aw_a;
      o_bt    = sel_b ? bt_b    : bt_a;
      o_res   = sel_b ? res_b   : res_a;
      o_rd    = sel_b ? rd_b    : rd_a;
   end

   typedef struct {
      logic        er, ew, regwrite, memtoreg, pcsrc, zero;
      logic [31:0] res, dw, add2;
      logic [4:0]  aw;
      int          exp_stall;
      logic        exp_rw, exp_mtr, exp_br, exp_mis;
      logic [4:0]  exp_aw;
      logic [31:0] exp_res, exp_rd;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model of instance A: word array plus last loaded value.
   logic [31:0] mem_m [256];
   logic [31:0] rd_m = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t model_step(input vec_t v, input int lat);
      vec_t e = v;
      bit   req = v.er | v.ew;
      bit   trap = 1'b0;
      bit   acc;
      int   wi = int'((v.res >> 2) & 32'hFF);
`ifdef MEM_MISALIGN_TRAP_EN
      trap = req && (v.res % 4 != 0);
`endif
      acc         = req && !trap;
      e.exp_stall = acc ? lat - 1 : 0;
      e.exp_rw    = v.regwrite && !trap;
      e.exp_mtr   = v.memtoreg;
      e.exp_aw    = v.aw;
      e.exp_res   = v.res;
      e.exp_br    = v.pcsrc && v.zero;
      e.exp_mis   = trap;
      if (acc && v.er) rd_m = mem_m[wi];
      if (acc && v.ew) mem_m[wi] = v.dw;
      e.exp_rd = rd_m;
      return e;
   endfunction

   task automatic drive(input vec_t v);
      er = v.er; ew = v.ew; regwrite = v.regwrite; memtoreg = v.memtoreg;
      pcsrc = v.pcsrc; zero = v.zero; res = v.res; dw = v.dw; add2 = v.add2; aw = v.aw;
   endtask

   task automatic drive_idle();
      er = 0; ew = 0; regwrite = 0; memtoreg = 0; pcsrc = 0; zero = 0;
      res = 0; dw = 0; add2 = 0; aw = 0;
   endtask

   task automatic do_txn(input vec_t v);
      @(negedge clk);
      drive(v);
      #1;
      for (int k = 0; k < v.exp_stall; k++) begin
         chk("stall_high", 32'(o_stall), 32'd1);
         chk("branch_in_stall", 32'(o_br), 32'd0);
         @(posedge clk);
         #1;
         chk("bubble_regwrite", 32'(o_rw), 32'd0);
         chk("bubble_memtoreg", 32'(o_mtr), 32'd0);
      end
      chk("stall_low", 32'(o_stall), 32'd0);
      chk("branch_taken", 32'(o_br), 32'(v.exp_br));
      chk("branch_target", o_bt, v.add2);
      @(posedge clk);
      #1;
      chk("out_regwrite", 32'(o_rw), 32'(v.exp_rw));
      chk("out_memtoreg", 32'(o_mtr), 32'(v.exp_mtr));
      chk("out_AW", 32'(o_aw), 32'(v.exp_aw));
      chk("res_out", o_res, v.exp_res);
      chk("rd_out", o_rd, v.exp_rd);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign", 32'(o_mis), 32'(v.exp_mis));
`endif
      $display("txn dut=%s er=%0b ew=%0b res=%h dw=%h AW=%0d -> rd_out=%h res_out=%h rw=%0b",
               sel_b ? "B" : "A", v.er, v.ew, v.res, v.dw, v.aw, o_rd, o_res, o_rw);
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic rw, input logic mtr,
                               input logic pc, input logic z, input logic [31:0] r_res,
                               input logic [31:0] r_dw, input logic [4:0] r_aw,
                               input logic [31:0] r_add2);
      vec_t v;
      v.er = r; v.ew = w; v.regwrite = rw; v.memtoreg = mtr; v.pcsrc = pc; v.zero = z;
      v.res = r_res; v.dw = r_dw; v.aw = r_aw; v.add2 = r_add2;
      v.exp_stall = 0; v.exp_rw = 0; v.exp_mtr = 0; v.exp_br = 0; v.exp_mis = 0;
      v.exp_aw = 0; v.exp_res = 0; v.exp_rd = 0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v, input int st, input logic rw, input logic mtr,
                               input logic [4:0] e_aw, input logic [31:0] e_res,
                               input logic [31:0] e_rd, input logic br);
      vec_t e = v;
      e.exp_stall = st; e.exp_rw = rw; e.exp_mtr = mtr; e.exp_aw = e_aw;
      e.exp_res = e_res; e.exp_rd = e_rd; e.exp_br = br; e.exp_mis = 0;
      return e;
   endfunction

   vec_t tbl [8];
   vec_t v, e;

   initial begin
      tbl[0] = ex(mk(0,1,0,0,0,0,32'h10,32'hDEADBEEF,5'd0,32'h0),   1,0,0,5'd0,32'h10,  32'h0,       0);
      tbl[1] = ex(mk(1,0,1,1,0,0,32'h10,32'h0,5'd5,32'h0),          1,1,1,5'd5,32'h10,  32'hDEADBEEF,0);
      tbl[2] = ex(mk(0,0,1,0,0,0,32'h1234,32'h0,5'd3,32'h0),        0,1,0,5'd3,32'h1234,32'hDEADBEEF,0);
      tbl[3] = ex(mk(0,0,0,0,1,1,32'h0,32'h0,5'd0,32'h40),          0,0,0,5'd0,32'h0,   32'hDEADBEEF,1);
      tbl[4] = ex(mk(1,0,1,1,1,1,32'h10,32'h0,5'd7,32'h80),         1,1,1,5'd7,32'h10,  32'hDEADBEEF,1);
      tbl[5] = ex(mk(1,1,1,1,0,0,32'h10,32'hCAFEF00D,5'd9,32'h0),   1,1,1,5'd9,32'h10,  32'hDEADBEEF,0);
      tbl[6] = ex(mk(1,0,1,1,0,0,32'h10,32'h0,5'd2,32'h0),          1,1,1,5'd2,32'h10,  32'hCAFEF00D,0);
      tbl[7] = ex(mk(0,0,1,0,1,0,32'h2C,32'h0,5'd4,32'h99),         0,1,0,5'd4,32'h2C,  32'hCAFEF00D,0);

      drive_idle();
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      chk("reset_regwrite", 32'(rw_a), 32'd0);
      chk("reset_memtoreg", 32'(mtr_a), 32'd0);
      chk("reset_AW", 32'(aw_a), 32'd0);
      chk("reset_res_out", res_a, 32'd0);
      chk("reset_rd_out", rd_a, 32'd0);
      chk("reset_stall", 32'(stall_a), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("reset_misalign", 32'(mis_a), 32'd0);
`endif
      @(negedge clk);
      rst_a = 1'b1;

      // Directed table; the model tracks state but the table supplies expectations.
      for (int i = 0; i < 8; i++) begin
         e = model_step(tbl[i], 2);
         do_txn(tbl[i]);
      end

      // Fill words 0..15 so every random load has a known value.
      for (int i = 0; i < 16; i++) begin
         v = mk(0, 1, 1'($urandom_range(0,1)), 0, 0, 0, 32'(i * 4), $urandom, 5'($urandom), 32'h0);
         do_txn(model_step(v, 2));
      end

      for (int i = 0; i < 150; i++) begin
         int sel = $urandom_range(0, 3);
         v = mk(sel == 1 || sel == 3, sel == 2 || sel == 3, 1'($urandom_range(0,1)),
                1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0,15) * 4)
                   | 32'($urandom_range(0,3)),
                $urandom, 5'($urandom), $urandom);
         do_txn(model_step(v, 2));
      end

      // Flush mid-access: the abandoned store must not land.
      @(negedge clk);
      drive(mk(0, 1, 1, 0, 0, 0, 32'h1C, 32'h5A5A5A5A, 5'd6, 32'h0));
      #1;
      chk("flush_stall", 32'(stall_a), 32'd1);
      @(negedge clk);
      drive_idle();
      #1;
      chk("flush_idle_stall", 32'(stall_a), 32'd0);
      do_txn(model_step(mk(1, 0, 1, 1, 0, 0, 32'h1C, 32'h0, 5'd11, 32'h0), 2));

`ifdef MEM_MISALIGN_TRAP_EN
      // Unaligned load traps: no stall, one-cycle misalign pulse, memory intact.
      @(negedge clk);
      drive(mk(1, 0, 1, 1, 0, 0, 32'h13, 32'h0, 5'd8, 32'h0));
      #1;
      chk("trap_no_stall", 32'(stall_a), 32'd0);
      @(posedge clk);
      #1;
      chk("trap_pulse", 32'(mis_a), 32'd1);
      chk("trap_regwrite", 32'(rw_a), 32'd0);
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      chk("trap_pulse_end", 32'(mis_a), 32'd0);
      do_txn(model_step(mk(1, 0, 1, 1, 0, 0, 32'h10, 32'h0, 5'd1, 32'h0), 2));
`endif

      // Instance B (MEM_LAT=4): reset during the second WAIT cycle aborts a store.
      @(negedge clk);
      drive_idle();
      sel_b = 1'b1;
      rst_b = 1'b1;
      do_txn(ex(mk(0,1,0,0,0,0,32'h24,32'h11111111,5'd0,32'h0), 3,0,0,5'd0,32'h24,32'h0,0));
      do_txn(ex(mk(1,0,1,1,0,0,32'h24,32'h0,5'd12,32'h0),       3,1,1,5'd12,32'h24,32'h11111111,0));
      @(negedge clk);
      drive(mk(0, 1, 1, 0, 0, 0, 32'h24, 32'h22222222, 5'd3, 32'h0));
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("rst_regwrite", 32'(rw_b), 32'd0);
      chk("rst_memtoreg", 32'(mtr_b), 32'd0);
      chk("rst_AW", 32'(aw_b), 32'd0);
      chk("rst_res_out", res_b, 32'd0);
      chk("rst_rd_out", rd_b, 32'd0);
      @(negedge clk);
      drive_idle();
      rst_b = 1'b1;
      do_txn(ex(mk(1,0,1,1,0,0,32'h24,32'h0,5'd13,32'h0),       3,1,1,5'd13,32'h24,32'h11111111,0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
